// File: rtl/CPU_package.sv
// Shared CPU types: ALU word width, opcode and flag encodings, sequencer states.
package CPU_package;

   localparam int unsigned DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } enum_alu_opcode_t;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } struct_alu_flag_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } enum_alu_seq_state_t;

endpackage

// File: rtl/alu_wide_legal_check.sv
// Flags double-word requests the two-pass sequencer cannot chain correctly.
module alu_wide_legal_check
   import CPU_package::*;
(
   input  enum_alu_opcode_t opcode,
   input  logic             mode,
   input  logic             wide,
   output logic             illegal_c
);

   logic legal_wide;

   // Only carry-chained ADD and bitwise AND/OR split cleanly into two halves.
   always_comb begin
      legal_wide = (mode && (opcode == OP_ADD)) ||
                   (!mode && ((opcode == OP_AND) || (opcode == OP_OR)));
      illegal_c  = wide && !legal_wide;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues single- or double-word operations to a combinational ALU and returns
// the combined result over a valid/ready response channel.
module alu_op_sequencer
   import CPU_package::*;
#(
   parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH,
   parameter int unsigned WIDE_W     = 2 * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  enum_alu_opcode_t      req_opcode,
   input  logic                  req_mode,
   input  logic                  req_wide,
   input  logic [WIDE_W-1:0]     req_a,
   input  logic [WIDE_W-1:0]     req_b,
   input  logic                  req_carry,
   output logic [DATA_WIDTH-1:0] alu_in_a,
   output logic [DATA_WIDTH-1:0] alu_in_b,
   output logic                  alu_input_carry,
   output enum_alu_opcode_t      alu_opcode,
   output logic                  alu_mode,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  struct_alu_flag_t      alu_out_flag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDE_W-1:0]     rsp_data,
   output struct_alu_flag_t      rsp_flag,
   output logic                  rsp_err
);

   enum_alu_seq_state_t   state;
   enum_alu_opcode_t      op_opcode;
   logic                  op_mode;
   logic                  op_wide;
   logic [WIDE_W-1:0]     op_a;
   logic [WIDE_W-1:0]     op_b;
   logic                  op_carry;
   logic [DATA_WIDTH-1:0] lo_res;
   logic                  lo_carry;
   logic                  lo_zero;
   logic                  illegal_c;
   struct_alu_flag_t      wide_flag;

   alu_wide_legal_check u_legal (
      .opcode    (req_opcode),
      .mode      (req_mode),
      .wide      (req_wide),
      .illegal_c (illegal_c)
   );

   // A wide result is zero only if both halves are zero.
   always_comb begin
      wide_flag      = alu_out_flag;
      wide_flag.zero = lo_zero & alu_out_flag.zero;
   end

   // ALU drive depends only on state and latched request fields.
   always_comb begin
      alu_in_a        = '0;
      alu_in_b        = '0;
      alu_input_carry = 1'b0;
      alu_opcode      = OP_ADD;
      alu_mode        = 1'b0;
      case (state)
         LO: begin
            alu_in_a        = op_a[DATA_WIDTH-1:0];
            alu_in_b        = op_b[DATA_WIDTH-1:0];
            alu_input_carry = op_carry;
            alu_opcode      = op_opcode;
            alu_mode        = op_mode;
         end
         HI: begin
            alu_in_a        = op_a[WIDE_W-1:DATA_WIDTH];
            alu_in_b        = op_b[WIDE_W-1:DATA_WIDTH];
            alu_input_carry = (op_opcode == OP_ADD) ? lo_carry : 1'b0;
            alu_opcode      = op_opcode;
            alu_mode        = op_mode;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_flag  <= '0;
         rsp_err   <= 1'b0;
         op_opcode <= OP_ADD;
         op_mode   <= 1'b0;
         op_wide   <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_carry  <= 1'b0;
         lo_res    <= '0;
         lo_carry  <= 1'b0;
         lo_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_opcode <= req_opcode;
                  op_mode   <= req_mode;
                  op_wide   <= req_wide;
                  op_a      <= req_a;
                  op_b      <= req_b;
                  op_carry  <= req_carry;
                  req_ready <= 1'b0;
                  if (illegal_c) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_flag  <= '0;
                  end else begin
                     state <= LO;
                  end
               end
            end
            LO: begin
               lo_res   <= alu_out;
               lo_carry <= alu_out_flag.carry;
               lo_zero  <= alu_out_flag.zero;
               if (op_wide) begin
                  state <= HI;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= {{(WIDE_W-DATA_WIDTH){1'b0}}, alu_out};
                  rsp_flag  <= alu_out_flag;
               end
            end
            HI: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_data  <= {alu_out, lo_res};
               rsp_flag  <= wide_flag;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 16-bit ALU
// and a scoreboard of expected responses.
module tb_alu_op_sequencer;
   import CPU_package::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   enum_alu_opcode_t req_opcode;
   logic             req_mode;
   logic             req_wide;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic             req_carry;
   logic [15:0]      alu_in_a;
   logic [15:0]      alu_in_b;
   logic             alu_input_carry;
   enum_alu_opcode_t alu_opcode;
   logic             alu_mode;
   logic [15:0]      alu_out;
   struct_alu_flag_t alu_out_flag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   struct_alu_flag_t rsp_flag;
   logic             rsp_err;

   typedef struct {
      enum_alu_opcode_t op;
      logic             mode;
      logic             wide;
      logic [31:0]      a;
      logic [31:0]      b;
      logic             cin;
      logic [31:0]      data;
      logic [3:0]       flag;   // {carry, zero, negative, overflow}
      logic             err;
      int               lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flag;
      logic        err;
      int          lat;
   } exp_t;

   localparam int NVEC = 14;
   vec_t vecs[NVEC];
   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc = 0;
   int   lat_seen = -1;
   logic [16:0] alu_sum;

   alu_op_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_opcode      (req_opcode),
      .req_mode        (req_mode),
      .req_wide        (req_wide),
      .req_a           (req_a),
      .req_b           (req_b),
      .req_carry       (req_carry),
      .alu_in_a        (alu_in_a),
      .alu_in_b        (alu_in_b),
      .alu_input_carry (alu_input_carry),
      .alu_opcode      (alu_opcode),
      .alu_mode        (alu_mode),
      .alu_out         (alu_out),
      .alu_out_flag    (alu_out_flag),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .rsp_flag        (rsp_flag),
      .rsp_err         (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU; SUB reports borrow in the carry flag.
   always_comb begin
      alu_sum      = '0;
      alu_out      = '0;
      alu_out_flag = '0;
      case (alu_opcode)
         OP_ADD: begin
            alu_sum = {1'b0, alu_in_a} + {1'b0, alu_in_b} + 17'(alu_input_carry);
            alu_out = alu_sum[15:0];
            alu_out_flag.carry    = alu_sum[16];
            alu_out_flag.overflow = (alu_in_a[15] == alu_in_b[15]) && (alu_sum[15] != alu_in_a[15]);
         end
         OP_SUB: begin
            alu_sum = {1'b0, alu_in_a} - {1'b0, alu_in_b} - 17'(alu_input_carry);
            alu_out = alu_sum[15:0];
            alu_out_flag.carry    = alu_sum[16];
            alu_out_flag.overflow = (alu_in_a[15] != alu_in_b[15]) && (alu_sum[15] != alu_in_a[15]);
         end
         OP_AND: alu_out = alu_in_a & alu_in_b;
         OP_OR:  alu_out = alu_in_a | alu_in_b;
         OP_XOR: alu_out = alu_in_a ^ alu_in_b;
         OP_NOT: alu_out = ~alu_in_a;
         OP_SHL: alu_out = alu_in_a << alu_in_b[3:0];
         OP_SHR: alu_out = alu_in_a >> alu_in_b[3:0];
         default: ;
      endcase
      alu_out_flag.zero     = (alu_out == 16'h0000);
      alu_out_flag.negative = alu_out[15];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: record first-valid latency, compare on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && lat_seen < 0) lat_seen = cyc - acc + 1;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual=response required=none data=%h", rsp_data);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_data", rsp_data, mon_e.data);
               check("rsp_flag", 32'(rsp_flag), 32'(mon_e.flag));
               check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
               check("latency", 32'(lat_seen), 32'(mon_e.lat));
            end
         end
      end
   end

   task automatic issue(input vec_t v);
      exp_t e;
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before_issue", 32'(req_ready), 32'd1);
      e.data = v.data; e.flag = v.flag; e.err = v.err; e.lat = v.lat;
      sb.push_back(e);
      req_opcode = v.op; req_mode = v.mode; req_wide = v.wide;
      req_a = v.a; req_b = v.b; req_carry = v.cin;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      lat_seen = -1;
      req_valid = 1'b0;
      // Scramble request fields; the latched copy must be used.
      req_a = $urandom; req_b = $urandom; req_carry = ~v.cin;
      req_opcode = OP_SHR; req_mode = ~v.mode; req_wide = ~v.wide;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{OP_ADD, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 4'b0000, 1'b0, 2};
      vecs[1]  = '{OP_ADD, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000, 1'b0, 3};
      vecs[2]  = '{OP_ADD, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100, 1'b0, 3};
      vecs[3]  = '{OP_AND, 1'b0, 1'b1, 32'h1234_5678, 32'hFF00_FF00, 1'b1, 32'h1200_5600, 4'b0000, 1'b0, 3};
      vecs[4]  = '{OP_SHL, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0004, 1'b0, 32'h0000_0000, 4'b0000, 1'b1, 1};
      vecs[5]  = '{OP_ADD, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0000, 1'b1, 1};
      vecs[6]  = '{OP_SUB, 1'b1, 1'b0, 32'hABCD_0005, 32'h1234_0007, 1'b0, 32'h0000_FFFE, 4'b1010, 1'b0, 2};
      vecs[7]  = '{OP_XOR, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0F0F, 1'b0, 32'h0000_0FF0, 4'b0000, 1'b0, 2};
      vecs[8]  = '{OP_OR,  1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001, 4'b0010, 1'b0, 3};
      vecs[9]  = '{OP_ADD, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100, 1'b0, 2};
      vecs[10] = '{OP_ADD, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 4'b0011, 1'b0, 3};
      vecs[11] = '{OP_ADD, 1'b1, 1'b1, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 32'h0002_0000, 4'b0000, 1'b0, 3};
      vecs[12] = '{OP_AND, 1'b0, 1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 32'h0000_00FF, 4'b0000, 1'b0, 3};
      vecs[13] = '{OP_SHL, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0004, 1'b0, 32'h0000_0010, 4'b0000, 1'b0, 2};

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
      req_opcode = OP_ADD; req_mode = 1'b0; req_wide = 1'b0;
      req_a = '0; req_b = '0; req_carry = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_flag", 32'(rsp_flag), 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("idle_alu_in_a", 32'(alu_in_a), 32'd0);
      check("idle_alu_in_b", 32'(alu_in_b), 32'd0);
      check("idle_alu_carry", 32'(alu_input_carry), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         issue(vecs[i]);
         wait_done();
      end

      // Wide ADD: carry from LO pass feeds the HI pass.
      issue(vecs[1]);
      @(negedge clk);
      check("lo_alu_in_a", 32'(alu_in_a), 32'h0000_FFFF);
      check("lo_alu_carry", 32'(alu_input_carry), 32'd0);
      @(negedge clk);
      check("hi_alu_in_a", 32'(alu_in_a), 32'h0000_0000);
      check("hi_add_carry", 32'(alu_input_carry), 32'd1);
      wait_done();

      // Wide AND: HI carry forced low even with req_carry set.
      issue(vecs[3]);
      @(negedge clk);
      check("lo_and_in_b", 32'(alu_in_b), 32'h0000_FF00);
      @(negedge clk);
      check("hi_and_in_a", 32'(alu_in_a), 32'h0000_1234);
      check("hi_and_carry", 32'(alu_input_carry), 32'd0);
      wait_done();

      // Backpressure: response held for 5 cycles, accepted on the 6th.
      @(posedge clk); #1 rsp_ready = 1'b0;
      issue(vecs[6]);
      for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_data", rsp_data, 32'h0000_FFFE);
         check("bp_rsp_flag", 32'(rsp_flag), 32'hA);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_req_ready", 32'(req_ready), 32'd1);
      check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during HI of a wide ADD aborts without a response.
      issue(vecs[2]);
      @(negedge clk);
      @(negedge clk);
      check("abort_hi_carry", 32'(alu_input_carry), 32'd1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Sequencer still works after the abort.
      issue(vecs[0]);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
